// File: rtl/id_stage.sv
// id_stage: Octa16 decode stage with regfile read addressing, ID/EX register and write scoreboard.
module id_stage #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [15:0]           if_instr,
  output logic [2:0]            rs1,
  output logic [2:0]            rs2,
  input  logic [DATA_WIDTH-1:0] r1,
  input  logic [DATA_WIDTH-1:0] r2,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [3:0]            id_op,
  output logic [2:0]            id_rd,
  output logic                  id_wr,
  output logic [DATA_WIDTH-1:0] id_a,
  output logic [DATA_WIDTH-1:0] id_b,
  output logic [DATA_WIDTH-1:0] id_imm,
  input  logic                  wb_en,
  input  logic [2:0]            wb_rd,
  input  logic                  flush
);
  logic [3:0] op;
  logic [2:0] rd, ra, rb;
  logic       rd1, rd2, wr, st_beq, hazard, accept;
  logic [7:0] sb, sb_set, sb_clr;
  always_comb begin
    op       = if_instr[15:12];
    rd       = if_instr[11:9];
    ra       = if_instr[8:6];
    rb       = if_instr[5:3];
    st_beq   = op[3:1] == 3'b101;
    rd1      = ~(op[3] & op[2]);
    rd2      = ~op[3] | st_beq;
    wr       = ~op[3] | (op[3:1] == 3'b100);
    rs1      = rd1 ? ra : 3'd0;
    rs2      = ~op[3] ? rb : st_beq ? rd : 3'd0;
    hazard   = if_valid & ((rd1 & sb[rs1]) | (rd2 & sb[rs2]) | (wr & sb[rd]));
    if_ready = ~hazard & (~id_valid | id_ready) & ~flush;
    accept   = if_valid & if_ready;
    sb_set   = (accept & wr) ? 8'd1 << rd : 8'd0;
    // a flushed writer will never reach writeback, so release its claim here
    sb_clr   = (wb_en ? 8'd1 << wb_rd : 8'd0) |
               ((flush & id_valid & id_wr) ? 8'd1 << id_rd : 8'd0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb       <= '0;
      id_valid <= 1'b0;
      id_op    <= '0;
      id_rd    <= '0;
      id_wr    <= 1'b0;
      id_a     <= '0;
      id_b     <= '0;
      id_imm   <= '0;
    end else begin
      sb <= ((sb & ~sb_clr) | sb_set) & 8'hFE;
      if (flush) begin
        id_valid <= 1'b0;
      end else if (accept) begin
        id_valid <= 1'b1;
        id_op    <= op;
        id_rd    <= rd;
        id_wr    <= wr & |rd;
        id_a     <= r1;
        id_b     <= r2;
        id_imm   <= {{(DATA_WIDTH-6){if_instr[5]}}, if_instr[5:0]};
      end else if (id_ready) begin
        id_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed stimulus for id_stage checked against an instruction-level model.
module tb_id_stage;
  logic        clk, rst, if_valid, if_ready, id_valid, id_ready, id_wr, wb_en, flush;
  logic [15:0] if_instr, r1, r2, id_a, id_b, id_imm, wb_val;
  logic [2:0]  rs1, rs2, id_rd, wb_rd;
  logic [3:0]  id_op;
  logic [15:0] regs [8];
  int n_cmp = 0, n_bad = 0;

  id_stage #(.DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .rs1(rs1), .rs2(rs2), .r1(r1), .r2(r2), .id_valid(id_valid), .id_ready(id_ready),
    .id_op(id_op), .id_rd(id_rd), .id_wr(id_wr), .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
    .wb_en(wb_en), .wb_rd(wb_rd), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign r1 = regs[rs1];
  assign r2 = regs[rs2];

  typedef struct {
    bit         rd1, rd2, wr;
    logic [2:0] s1, s2, d;
  } dec_t;

  function automatic dec_t dec(logic [15:0] i);
    dec_t d;
    int   op;
    op = int'(i[15:12]);
    d.rd1 = 0; d.rd2 = 0; d.wr = 0; d.s1 = 0; d.s2 = 0; d.d = i[11:9];
    if (op < 8) begin
      d.rd1 = 1; d.rd2 = 1; d.wr = 1; d.s1 = i[8:6]; d.s2 = i[5:3];
    end else if (op < 10) begin
      d.rd1 = 1; d.wr = 1; d.s1 = i[8:6];
    end else if (op < 12) begin
      d.rd1 = 1; d.rd2 = 1; d.s1 = i[8:6]; d.s2 = i[11:9];
    end
    return d;
  endfunction

  bit [7:0]    m_sb;
  bit          m_valid, m_wr, m_acc;
  logic [3:0]  m_op;
  logic [2:0]  m_rd;
  logic [15:0] m_a, m_b, m_imm;
  dec_t        md;

  function automatic bit exp_ready();
    dec_t d;
    bit   haz;
    d   = dec(if_instr);
    haz = if_valid && ((d.rd1 && m_sb[d.s1]) || (d.rd2 && m_sb[d.s2]) || (d.wr && m_sb[d.d]));
    return !haz && (!m_valid || id_ready) && !flush;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sb    = '0;
      m_valid = 0;
    end else begin
      md    = dec(if_instr);
      m_acc = if_valid && exp_ready();
      if (wb_en && wb_rd != 0) m_sb[wb_rd] = 0;
      if (flush) begin
        if (m_valid && m_wr) m_sb[m_rd] = 0;
        m_valid = 0;
      end else if (m_acc) begin
        m_valid = 1;
        m_op    = if_instr[15:12];
        m_rd    = md.d;
        m_wr    = md.wr && md.d != 0;
        m_a     = regs[md.s1];
        m_b     = regs[md.s2];
        m_imm   = 16'(signed'(if_instr[5:0]));
        if (m_wr) m_sb[md.d] = 1;
      end else if (id_ready) begin
        m_valid = 0;
      end
      if (wb_en && wb_rd != 0) regs[wb_rd] <= wb_val;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      md = dec(if_instr);
      chk("rs1", rs1, md.rd1 ? md.s1 : 3'd0);
      chk("rs2", rs2, md.rd2 ? md.s2 : 3'd0);
      chk("if_ready", if_ready, exp_ready());
      chk("id_valid", id_valid, m_valid);
      if (m_valid) begin
        chk("id_op", id_op, m_op);
        chk("id_rd", id_rd, m_rd);
        chk("id_wr", id_wr, m_wr);
        chk("id_a", id_a, m_a);
        chk("id_b", id_b, m_b);
        chk("id_imm", id_imm, m_imm);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(logic [2:0] r, logic [15:0] v);
    wb_en = 1; wb_rd = r; wb_val = v;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = '0;
    rst = 1; if_valid = 0; if_instr = '0; id_ready = 1; wb_en = 0; wb_rd = 0; wb_val = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", id_valid, 0); chk("rst_op", id_op, 0); chk("rst_rd", id_rd, 0);
    chk("rst_wr", id_wr, 0); chk("rst_a", id_a, 0); chk("rst_b", id_b, 0);
    chk("rst_imm", id_imm, 0); chk("rst_ready", if_ready, 1);
    rst = 0;
    // ADDI r1,r0,5
    if_valid = 1; if_instr = 16'h8205;
    @(negedge clk); chk("t1_ready", if_ready, 1);
    cyc();
    // ADD r2,r1,r1 must wait for r1
    if_instr = 16'h0448;
    @(negedge clk);
    chk("t1_valid", id_valid, 1); chk("t1_op", id_op, 8); chk("t1_rd", id_rd, 1);
    chk("t1_wr", id_wr, 1); chk("t1_imm", id_imm, 16'h0005); chk("t2_stall", if_ready, 0);
    cyc();
    wb(1, 16'd5);
    @(negedge clk); chk("t2_nobypass", if_ready, 0); chk("t2_drain", id_valid, 0);
    cyc();
    wb_en = 0;
    @(negedge clk); chk("t2_go", if_ready, 1);
    cyc();
    // ADDI r0,r0,-1
    if_instr = 16'h803F;
    @(negedge clk);
    chk("t2_a", id_a, 5); chk("t2_b", id_b, 5); chk("t2_rd", id_rd, 2); chk("t3_ready", if_ready, 1);
    cyc();
    if_instr = 16'h8001;
    @(negedge clk);
    chk("t3_wr", id_wr, 0); chk("t3_imm", id_imm, 16'hFFFF); chk("t3_nostall", if_ready, 1);
    cyc();
    // execute back-pressure for three cycles
    if_instr = 16'h8C07; id_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_hold_imm", id_imm, 16'h0001); chk("t4_hold_valid", id_valid, 1);
      chk("t4_ready", if_ready, 0);
      cyc();
    end
    id_ready = 1;
    @(negedge clk); chk("t4_release", if_ready, 1);
    cyc();
    if_valid = 0; wb(2, 16'h0022);
    @(negedge clk); chk("t4_rd", id_rd, 6); chk("t4_imm", id_imm, 16'h0007);
    cyc();
    wb(6, 16'h0066);
    cyc();
    // LD r3,[r1] then flush it
    wb_en = 0; if_valid = 1; if_instr = 16'h9640;
    cyc();
    if_valid = 0; flush = 1;
    @(negedge clk); chk("t5_ld_rd", id_rd, 3); chk("t5_flush_ready", if_ready, 0);
    cyc();
    flush = 0; if_valid = 1; if_instr = 16'h08D8;
    @(negedge clk); chk("t5_killed", id_valid, 0); chk("t5_nostall", if_ready, 1);
    cyc();
    // fill sb with r1..r3, then reset mid-flight
    if_instr = 16'h8205; wb(4, 16'h0044);
    @(negedge clk); chk("t5_rd", id_rd, 4); chk("t6_ready1", if_ready, 1);
    cyc();
    wb_en = 0; if_instr = 16'h8405;
    cyc();
    if_instr = 16'h8605;
    cyc();
    if_valid = 0;
    @(negedge clk); chk("t6_pre_valid", id_valid, 1);
    rst = 1;
    #1; chk("t6_async_valid", id_valid, 0); chk("t6_async_rd", id_rd, 0);
    if_valid = 1; if_instr = 16'h0850;
    #1; chk("t6_sb_clear", if_ready, 1);
    cyc();
    rst = 0;
    @(negedge clk); chk("t6_after_rst", if_ready, 1);
    cyc();
    // ST r5,[r1]; HALT; reserved
    if_instr = 16'hAA40;
    @(negedge clk); chk("st_rs2", rs2, 5);
    cyc();
    if_instr = 16'hF000;
    @(negedge clk); chk("halt_rs1", rs1, 0);
    cyc();
    if_instr = 16'hC1C8;
    @(negedge clk); chk("rsvd_rs2", rs2, 0);
    cyc();
    if_valid = 0;
    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
